// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: bus word, instruction-cache frame and cache FSM state.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // Wide enough for the tag of any cache with two or more sets; narrower tags are zero-extended.
  localparam int ICACHE_TAG_W = 30;
  typedef logic [ICACHE_TAG_W-1:0] icache_tag_t;

  typedef struct packed {
    logic        valid;
    icache_tag_t tag;
    word_t       data;
  } icache_frame_t;

  typedef enum logic {
    IDLE,
    FETCH
  } icache_state_t;

endpackage

// File: rtl/icache_ctrl.sv
// Direct-mapped, read-only, one-word-per-line instruction cache between fetch and the memory arbiter.
module icache_ctrl
  import cpu_types_pkg::*;
#(
  parameter int SETS         = 16,
  parameter int RESET_PC_TAG = 0
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  imemREN,
  input  word_t imemaddr,
  input  logic  flush,
  output logic  ihit,
  output word_t imemload,
  output logic  iREN,
  output word_t iaddr,
  input  logic  iwait,
  input  word_t iload,
  output word_t hit_count,
  output word_t miss_count
);

  localparam int IDX_W = $clog2(SETS);

  icache_state_t state_q, state_d;
  icache_frame_t frame_q [SETS];
  word_t         miss_addr_q, miss_addr_d;
  word_t         hit_count_q, miss_count_q;

  logic [IDX_W-1:0] idx, miss_idx;
  icache_tag_t      tag, miss_tag;
  logic             lookup_hit, fill, hit_inc, miss_inc;
  logic             unused_offset;

  assign idx           = imemaddr[IDX_W+1:2];
  assign tag           = icache_tag_t'(imemaddr >> (IDX_W + 2));
  assign miss_idx      = miss_addr_q[IDX_W+1:2];
  assign miss_tag      = icache_tag_t'(miss_addr_q >> (IDX_W + 2));
  assign unused_offset = ^imemaddr[1:0];

  assign lookup_hit = frame_q[idx].valid && (frame_q[idx].tag == tag);
  assign fill       = (state_q == FETCH) && !iwait;

  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    ihit        = 1'b0;
    imemload    = '0;
    iREN        = 1'b0;
    iaddr       = '0;
    hit_inc     = 1'b0;
    miss_inc    = 1'b0;
    case (state_q)
      IDLE: begin
        if (imemREN) begin
          if (lookup_hit) begin
            ihit     = 1'b1;
            imemload = frame_q[idx].data;
            hit_inc  = 1'b1;
          end else begin
            miss_inc    = 1'b1;
            miss_addr_d = {imemaddr[31:2], 2'b00};
            state_d     = FETCH;
          end
        end
      end
      FETCH: begin
        // Request held steady until the arbiter answers; the core's address is ignored here.
        iREN  = 1'b1;
        iaddr = miss_addr_q;
        if (!iwait) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      miss_addr_q  <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      if (hit_inc)  hit_count_q  <= hit_count_q + 32'd1;
      if (miss_inc) miss_count_q <= miss_count_q + 32'd1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < SETS; i++) begin
        frame_q[i] <= '{valid: 1'b0, tag: icache_tag_t'(RESET_PC_TAG), data: '0};
      end
    end else begin
      if (flush) begin
        for (int i = 0; i < SETS; i++) frame_q[i].valid <= 1'b0;
      end
      // A fill coinciding with flush still lands, but stays invalid.
      if (fill) frame_q[miss_idx] <= '{valid: !flush, tag: miss_tag, data: iload};
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed bench for icache_ctrl: a scripted arbiter plus hand-computed expectations.
module tb_icache_ctrl;
  import cpu_types_pkg::*;

  logic  CLK = 1'b0;
  logic  nRST;
  logic  imemREN;
  word_t imemaddr;
  logic  flush;
  logic  ihit;
  word_t imemload;
  logic  iREN;
  word_t iaddr;
  logic  iwait;
  word_t iload;
  word_t hit_count;
  word_t miss_count;

  int vld_cnt = 0;
  int err_cnt = 0;
  int exp_hits = 0;
  int exp_miss = 0;

  icache_ctrl #(.SETS(16), .RESET_PC_TAG(0)) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .imemREN    (imemREN),
    .imemaddr   (imemaddr),
    .flush      (flush),
    .ihit       (ihit),
    .imemload   (imemload),
    .iREN       (iREN),
    .iaddr      (iaddr),
    .iwait      (iwait),
    .iload      (iload),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vld_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic check_counts(input string tag);
    check_val({tag, "_hits"}, hit_count, exp_hits);
    check_val({tag, "_miss"}, miss_count, exp_miss);
  endtask

  // Miss on addr, arbiter stalls for 'waits' cycles then returns data; core shows 'alt' while stalled.
  task automatic fetch_miss(input word_t addr, input word_t data, input int waits,
                            input word_t alt, input logic flush_last);
    @(negedge CLK);
    imemREN = 1'b1; imemaddr = addr; iwait = 1'b1; flush = 1'b0;
    #2;
    check_val("miss_ihit", ihit, 0);
    check_val("miss_iren", iREN, 0);
    exp_miss++;
    for (int w = 0; w <= waits; w++) begin
      @(negedge CLK);
      imemaddr = alt;
      iwait    = (w < waits);
      iload    = (w < waits) ? 32'hBAD0BAD0 : data;
      flush    = (w == waits) && flush_last;
      #2;
      check_val("fetch_iren", iREN, 1);
      check_val("fetch_iaddr", iaddr, addr);
      check_val("fetch_ihit", ihit, 0);
    end
    @(posedge CLK);
    #1;
    flush = 1'b0; iwait = 1'b1;
  endtask

  task automatic lookup_hit(input word_t addr, input word_t data, input logic fl);
    @(negedge CLK);
    imemREN = 1'b1; imemaddr = addr; flush = fl;
    #2;
    check_val("hit_ihit", ihit, 1);
    check_val("hit_data", imemload, data);
    check_val("hit_iren", iREN, 0);
    check_val("hit_iaddr", iaddr, 0);
    exp_hits++;
    @(posedge CLK);
    #1;
    flush = 1'b0;
  endtask

  task automatic idle_check(input string tag);
    @(negedge CLK);
    imemREN = 1'b0; flush = 1'b0;
    #2;
    check_val({tag, "_ihit"}, ihit, 0);
    check_val({tag, "_load"}, imemload, 0);
    check_val({tag, "_iren"}, iREN, 0);
    check_counts(tag);
  endtask

  initial begin
    nRST = 1'b0; imemREN = 1'b1; imemaddr = 32'h40; flush = 1'b0;
    iwait = 1'b1; iload = '0;
    #2;
    check_val("rst_ihit", ihit, 0);
    check_val("rst_iren", iREN, 0);
    check_val("rst_iaddr", iaddr, 0);
    check_val("rst_load", imemload, 0);
    check_counts("rst");
    @(negedge CLK); @(negedge CLK);
    imemREN = 1'b0;
    nRST = 1'b1;

    // Cold miss with three stall cycles, then same-address hit.
    fetch_miss(32'h40, 32'hDEADBEEF, 3, 32'h40, 1'b0);
    lookup_hit(32'h40, 32'hDEADBEEF, 1'b0);
    idle_check("cold");

    // Conflict eviction on index 0.
    fetch_miss(32'h0, 32'h11111111, 1, 32'h0, 1'b0);
    lookup_hit(32'h0, 32'h11111111, 1'b0);
    fetch_miss(32'h40, 32'h22222222, 0, 32'h40, 1'b0);
    fetch_miss(32'h0, 32'h11111111, 0, 32'h0, 1'b0);
    idle_check("conflict");

    // Core address moves during fetch; a would-hit address stays blocked while stalled.
    fetch_miss(32'h100, 32'hAAAA0100, 1, 32'h104, 1'b0);
    fetch_miss(32'h104, 32'hBBBB0104, 2, 32'h100, 1'b0);
    lookup_hit(32'h100, 32'hAAAA0100, 1'b0);
    lookup_hit(32'h104, 32'hBBBB0104, 1'b0);
    idle_check("addrchg");

    // Flush coinciding with the fill discards it and clears every other line.
    fetch_miss(32'h200, 32'hCCCC0200, 1, 32'h200, 1'b1);
    fetch_miss(32'h200, 32'hCCCC0200, 0, 32'h200, 1'b0);
    fetch_miss(32'h104, 32'hBBBB0104, 0, 32'h104, 1'b0);
    lookup_hit(32'h200, 32'hCCCC0200, 1'b1);
    fetch_miss(32'h200, 32'hCCCC0200, 0, 32'h200, 1'b0);
    fetch_miss(32'h104, 32'hBBBB0104, 0, 32'h104, 1'b0);
    idle_check("flush");

    // Warm every set, then 20 back-to-back hits with no arbiter traffic.
    for (int i = 0; i < 16; i++) begin
      fetch_miss(32'(i * 4), 32'hC0DE0000 + 32'(i * 4), 0, 32'(i * 4), 1'b0);
    end
    idle_check("warm");
    for (int i = 0; i < 20; i++) begin
      lookup_hit(32'((i % 16) * 4), 32'hC0DE0000 + 32'((i % 16) * 4), 1'b0);
    end
    idle_check("steady");

    // Asynchronous reset while a fetch is outstanding.
    @(negedge CLK);
    imemREN = 1'b1; imemaddr = 32'h300; iwait = 1'b1;
    @(negedge CLK);
    #2;
    check_val("prerst_iren", iREN, 1);
    #1 nRST = 1'b0;
    #1;
    check_val("asyncrst_iren", iREN, 0);
    check_val("asyncrst_iaddr", iaddr, 0);
    exp_hits = 0; exp_miss = 0;
    check_counts("asyncrst");
    @(negedge CLK);
    imemREN = 1'b0;
    nRST = 1'b1;
    fetch_miss(32'h0, 32'h5A5A5A5A, 0, 32'h0, 1'b0);
    lookup_hit(32'h0, 32'h5A5A5A5A, 1'b0);
    idle_check("postrst");

    $display("== %0d vectors applied, %0d miscompares ==", vld_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got %0d want %0d", 1, 0);
    $fatal(1, "timeout");
  end

endmodule
